// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and op-class helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SLL   = 4'h5,
    OP_SRL   = 4'h6,
    OP_SRA   = 4'h7,
    OP_SLT   = 4'h8,
    OP_SLTU  = 4'h9,
    OP_MUL   = 4'hA,
    OP_MULHU = 4'hB,
    OP_DIV   = 4'hC,
    OP_DIVU  = 4'hD,
    OP_REM   = 4'hE,
    OP_REMU  = 4'hF
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } alu_state_t;

  function automatic logic is_mul(input alu_op_t op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div(input alu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator.
// One bit per cycle for WIDTH cycles; done_o flags the cycle of the last iteration.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic [SHW-1:0]     cnt_q;
  logic               run_q, div_q, hi_q, rem_q, neg_quo_q, neg_rem_q;
  logic [WIDTH:0]     add_sum, trial;
  logic [WIDTH-1:0]   quo, rmd;
  logic               signed_div, sgn_a, sgn_b;
  alu_op_t            op;

  assign op         = alu_op_t'(op_i);
  assign signed_div = (op == OP_DIV) || (op == OP_REM);
  assign sgn_a      = signed_div && a_i[WIDTH-1];
  assign sgn_b      = signed_div && b_i[WIDTH-1];

  // Multiply: acc = {partial high, remaining multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    trial   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    if (!div_q)
      acc_d = {add_sum, acc_q[WIDTH-1:1]};
    else if (!trial[WIDTH])
      acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      div_q     <= 1'b0;
      hi_q      <= 1'b0;
      rem_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (start_i) begin
      div_q     <= is_div(op);
      hi_q      <= (op == OP_MULHU);
      rem_q     <= (op == OP_REM) || (op == OP_REMU);
      // A zero divisor keeps the all-ones quotient unsigned; the remainder then equals a.
      neg_quo_q <= (sgn_a ^ sgn_b) && (b_i != '0);
      neg_rem_q <= sgn_a;
      acc_q     <= {{WIDTH{1'b0}}, (sgn_a ? -a_i : a_i)};
      opnd_q    <= sgn_b ? -b_i : b_i;
      cnt_q     <= '0;
      run_q     <= 1'b1;
    end else if (run_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + SHW'(1);
      if (done_o) run_q <= 1'b0;
    end
  end

  assign done_o = run_q && (cnt_q == SHW'(WIDTH - 1));
  assign quo    = acc_q[WIDTH-1:0];
  assign rmd    = acc_q[2*WIDTH-1:WIDTH];

  // Sign fix-up is applied on the way out, in the cycle the result is captured.
  always_comb begin
    if (!div_q)
      result_o = hi_q ? rmd : quo;
    else if (rem_q)
      result_o = neg_rem_q ? -rmd : rmd;
    else
      result_o = neg_quo_q ? -quo : quo;
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops computed here, MUL/DIV family delegated to seq_muldiv.
// Every result is captured in the first DONE cycle and held until out_ready.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             lt,
  output logic             ltu,
  output logic             busy
);

  alu_state_t       state_q;
  alu_op_t          op_q, op_in;
  logic [WIDTH-1:0] a_q, b_q, result_q, result_d, md_result;
  logic             zero_q, lt_q, ltu_q, out_valid_q, busy_q, in_ready_q;
  logic             lt_d, ltu_d, md_start, md_done;
  logic [SHW-1:0]   shamt;

  assign op_in    = alu_op_t'(op);
  assign md_start = (state_q == ST_IDLE) && in_valid && (is_mul(op_in) || is_div(op_in));
  assign shamt    = b_q[SHW-1:0];
  assign lt_d     = $signed(a_q) < $signed(b_q);
  assign ltu_d    = a_q < b_q;

  seq_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (md_start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .done_o   (md_done),
    .result_o (md_result)
  );

  always_comb begin
    result_d = '0;
    case (op_q)
      OP_ADD:  result_d = a_q + b_q;
      OP_SUB:  result_d = a_q - b_q;
      OP_AND:  result_d = a_q & b_q;
      OP_OR:   result_d = a_q | b_q;
      OP_XOR:  result_d = a_q ^ b_q;
      OP_SLL:  result_d = a_q << shamt;
      OP_SRL:  result_d = a_q >> shamt;
      OP_SRA:  result_d = $signed(a_q) >>> shamt;
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, lt_d};
      OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, ltu_d};
      OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: result_d = md_result;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      lt_q        <= 1'b0;
      ltu_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            op_q       <= op_in;
            in_ready_q <= 1'b0;
            if (is_mul(op_in)) begin
              state_q <= ST_MUL;
              busy_q  <= 1'b1;
            end else if (is_div(op_in)) begin
              state_q <= ST_DIV;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (md_done) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
          end
        end
        ST_DONE: begin
          // First DONE cycle captures the result; afterwards wait for the consumer.
          if (!out_valid_q) begin
            result_q    <= result_d;
            zero_q      <= (result_d == '0);
            lt_q        <= lt_d;
            ltu_q       <= ltu_d;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign lt        = lt_q;
  assign ltu       = ltu_q;
  assign busy      = busy_q;

endmodule
